// File: rtl/iic_cmd_sequencer.sv
// Walks a command ROM and feeds write/read/delay/end commands to the I2C master.
// One transaction in flight; reads are returned, timeouts are flagged sticky.
module iic_cmd_sequencer #(
  parameter logic [6:0] SLV_ADDR   = 7'h21,
  parameter int         ADDR_W     = 8,
  parameter int         DELAY_UNIT = 1000,
  parameter int         TIMEOUT    = 4096,
  parameter int         GAP        = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [17:0]       rom_data_i,
  output logic [6:0]        Slv_Addr_o,
  output logic [7:0]        Reg_Addr_o,
  output logic [7:0]        Data_o,
  output logic              wr_o,
  output logic              send_o,
  input  logic              iic_done_i,
  input  logic [7:0]        iic_rd_data_i,
  output logic [7:0]        rd_data_o,
  output logic              rd_valid_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o,
  output logic [ADDR_W-1:0] err_idx_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam int DW = 16 + $clog2(DELAY_UNIT + 1);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_SEND   = 4'd3;
  localparam logic [3:0] S_WAIT   = 4'd4;
  localparam logic [3:0] S_GAP    = 4'd5;
  localparam logic [3:0] S_DELAY  = 4'd6;
  localparam logic [3:0] S_FINISH = 4'd7;
  localparam logic [3:0] S_FAIL   = 4'd8;

  logic [3:0]    state;
  logic [TW-1:0] tcnt;
  logic [GW-1:0] gcnt;
  logic [DW-1:0] dcnt;
  logic          last;

  assign last   = &rom_addr_o;
  assign send_o = (state == S_SEND);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      rom_addr_o <= '0;
      Slv_Addr_o <= '0;
      Reg_Addr_o <= '0;
      Data_o     <= '0;
      wr_o       <= 1'b0;
      rd_data_o  <= '0;
      rd_valid_o <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
      err_idx_o  <= '0;
      tcnt       <= '0;
      gcnt       <= '0;
      dcnt       <= '0;
    end else begin
      rd_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state      <= S_FETCH;
            rom_addr_o <= '0;
            Slv_Addr_o <= SLV_ADDR;
            busy_o     <= 1'b1;
            done_o     <= 1'b0;
            error_o    <= 1'b0;
            err_idx_o  <= '0;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          unique case (rom_data_i[17:16])
            2'b00, 2'b01: begin
              Reg_Addr_o <= rom_data_i[15:8];
              Data_o     <= rom_data_i[7:0];
              wr_o       <= rom_data_i[16];
              state      <= S_SEND;
            end
            2'b10: begin
              dcnt  <= DW'(rom_data_i[15:0]) * DW'(DELAY_UNIT);
              state <= S_DELAY;
            end
            default: state <= S_FINISH;
          endcase
        end
        S_SEND: begin
          // the send cycle is the first cycle of the timeout window
          tcnt  <= TW'(1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (iic_done_i) begin
            if (wr_o) begin
              rd_data_o  <= iic_rd_data_i;
              rd_valid_o <= 1'b1;
            end
            gcnt  <= '0;
            state <= S_GAP;
          end else if (tcnt == TW'(TIMEOUT - 1)) begin
            error_o   <= 1'b1;
            err_idx_o <= rom_addr_o;
            state     <= S_FAIL;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_GAP: begin
          if (gcnt == GW'(GAP - 1)) begin
            if (last) begin
              state <= S_FINISH;
            end else begin
              rom_addr_o <= rom_addr_o + ADDR_W'(1);
              state      <= S_FETCH;
            end
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        S_DELAY: begin
          // zero and one both leave after a single cycle
          if (dcnt <= DW'(1)) begin
            if (last) begin
              state <= S_FINISH;
            end else begin
              rom_addr_o <= rom_addr_o + ADDR_W'(1);
              state      <= S_FETCH;
            end
          end else begin
            dcnt <= dcnt - DW'(1);
          end
        end
        S_FINISH: begin
          done_o <= 1'b1;
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        S_FAIL: begin
          busy_o <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_cmd_sequencer.sv
// Bench for iic_cmd_sequencer: ROM and master models plus a
// transaction-timing reference built from the command table.
module tb_iic_cmd_sequencer;

  localparam int AW   = 4;
  localparam int N    = 16;
  localparam int DU   = 10;
  localparam int TO   = 64;
  localparam int GP   = 16;
  localparam int MAXT = 4096;
  localparam logic [6:0] SA = 7'h21;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-1:0] rom_addr_o;
  logic [17:0]   rom_data_i = '0;
  logic [6:0]    Slv_Addr_o;
  logic [7:0]    Reg_Addr_o;
  logic [7:0]    Data_o;
  logic          wr_o;
  logic          send_o;
  logic          iic_done_i = 1'b0;
  logic [7:0]    iic_rd_data_i = '0;
  logic [7:0]    rd_data_o;
  logic          rd_valid_o;
  logic          busy_o;
  logic          done_o;
  logic          error_o;
  logic [AW-1:0] err_idx_o;

  iic_cmd_sequencer #(
    .SLV_ADDR(SA), .ADDR_W(AW), .DELAY_UNIT(DU),
    .TIMEOUT(TO), .GAP(GP)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i),
    .Slv_Addr_o(Slv_Addr_o), .Reg_Addr_o(Reg_Addr_o),
    .Data_o(Data_o), .wr_o(wr_o), .send_o(send_o),
    .iic_done_i(iic_done_i), .iic_rd_data_i(iic_rd_data_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .err_idx_o(err_idx_o)
  );

  always #5 clk = ~clk;

  logic [17:0] rom [N];
  int          lat [N];
  logic [7:0]  rdv [N];

  always @(posedge clk) rom_data_i <= rom[rom_addr_o];

  bit         e_snd [MAXT];
  logic [7:0] e_reg [MAXT];
  logic [7:0] e_dat [MAXT];
  bit         e_wr  [MAXT];
  int         e_idx [MAXT];
  bit         e_dn  [MAXT];
  logic [7:0] e_dnd [MAXT];
  bit         e_dwr [MAXT];
  bit         e_rv  [MAXT];
  logic [7:0] e_rvd [MAXT];
  int         t_end, t_err, n_exp, exp_idx;
  bit         exp_done, exp_err;
  logic [7:0] last_rd = '0;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int t,
                     input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s t=%0d: got %0h expected %0h", tag, t, got, exp);
    end
  endtask

  task automatic rst_chk(input string nm);
    chk({nm, ".send"}, 0, send_o, 0);
    chk({nm, ".busy"}, 0, busy_o, 0);
    chk({nm, ".done"}, 0, done_o, 0);
    chk({nm, ".error"}, 0, error_o, 0);
    chk({nm, ".slv"}, 0, Slv_Addr_o, 0);
    chk({nm, ".reg"}, 0, Reg_Addr_o, 0);
    chk({nm, ".data"}, 0, Data_o, 0);
    chk({nm, ".wr"}, 0, wr_o, 0);
    chk({nm, ".rd_data"}, 0, rd_data_o, 0);
    chk({nm, ".rd_valid"}, 0, rd_valid_o, 0);
    chk({nm, ".rom_addr"}, 0, rom_addr_o, 0);
    chk({nm, ".err_idx"}, 0, err_idx_o, 0);
  endtask

  task automatic clr_tbl();
    for (int a = 0; a < N; a++) begin
      rom[a] = 18'h3_0000;
      lat[a] = $urandom_range(1, TO - 1);
      rdv[a] = 8'($urandom);
    end
  endtask

  // Timeline per entry, cycles counted from the start edge:
  // fetch f, decode f+1, send f+2; done at send+lat; gap then next fetch.
  task automatic build_model();
    int t, ts, l, d, a;
    bit fin;
    for (int i = 0; i < MAXT; i++) begin
      e_snd[i] = 0;
      e_dn[i]  = 0;
      e_rv[i]  = 0;
    end
    exp_done = 0;
    exp_err  = 0;
    exp_idx  = 0;
    t_err    = MAXT;
    n_exp    = 0;
    t   = 1;
    a   = 0;
    fin = 0;
    while (!fin) begin
      logic [1:0] op;
      op = rom[a][17:16];
      if (op == 2'b11) begin
        t_end    = t + 3;
        exp_done = 1;
        fin      = 1;
      end else begin
        if (op[1]) begin
          d = int'(rom[a][15:0]) * DU;
          if (d == 0) d = 1;
          t = t + 2 + d;
        end else begin
          ts = t + 2;
          e_snd[ts] = 1;
          e_reg[ts] = rom[a][15:8];
          e_dat[ts] = rom[a][7:0];
          e_wr[ts]  = op[0];
          e_idx[ts] = a;
          n_exp++;
          l = lat[a];
          if (l < 1 || l > TO - 1) begin
            exp_err = 1;
            exp_idx = a;
            t_err   = ts + TO;
            t_end   = t_err + 1;
            fin     = 1;
          end else begin
            e_dn[ts+l]  = 1;
            e_dnd[ts+l] = rdv[a];
            e_dwr[ts+l] = op[0];
            if (op[0]) begin
              e_rv[ts+l+1]  = 1;
              e_rvd[ts+l+1] = rdv[a];
              last_rd = rdv[a];
            end
            t = ts + l + GP + 1;
          end
        end
        if (!fin) begin
          if (a == N - 1) begin
            t_end    = t + 1;
            exp_done = 1;
            fin      = 1;
          end else begin
            a++;
          end
        end
      end
    end
    if (t_end > MAXT - 4) begin
      $display("FAIL model: table too long (%0d cycles)", t_end);
      $fatal(1, "model overflow");
    end
  endtask

  task automatic run_seq(input string nm, input bit noisy);
    int sends;
    build_model();
    sends = 0;
    @(negedge clk);
    start_i = 1'b1;
    for (int t = 1; t <= t_end + 1; t++) begin
      @(negedge clk);
      start_i = noisy && (t < t_end) && ($urandom_range(0, 5) == 0);
      chk({nm, ".send"}, t, send_o, e_snd[t]);
      chk({nm, ".busy"}, t, busy_o, t < t_end);
      chk({nm, ".done"}, t, done_o, exp_done && t >= t_end);
      chk({nm, ".error"}, t, error_o, exp_err && t >= t_err);
      chk({nm, ".rd_valid"}, t, rd_valid_o, e_rv[t]);
      if (e_snd[t]) begin
        sends++;
        chk({nm, ".reg"}, t, Reg_Addr_o, e_reg[t]);
        chk({nm, ".data"}, t, Data_o, e_dat[t]);
        chk({nm, ".wr"}, t, wr_o, e_wr[t]);
        chk({nm, ".slv"}, t, Slv_Addr_o, SA);
        chk({nm, ".rom_addr"}, t, rom_addr_o, e_idx[t]);
      end
      if (e_rv[t]) chk({nm, ".rd_data"}, t, rd_data_o, e_rvd[t]);
      if (e_dn[t]) chk({nm, ".wr_hold"}, t, wr_o, e_dwr[t]);
      iic_done_i    = e_dn[t];
      iic_rd_data_i = e_dn[t] ? e_dnd[t] : 8'($urandom);
    end
    iic_done_i = 1'b0;
    start_i    = 1'b0;
    chk({nm, ".n_send"}, t_end, sends, n_exp);
    chk({nm, ".rd_hold"}, t_end, rd_data_o, last_rd);
    if (exp_err) chk({nm, ".err_idx"}, t_end, err_idx_o, exp_idx);
  endtask

  initial begin
    for (int a = 0; a < N; a++) rom[a] = 18'h3_0000;
    repeat (3) @(negedge clk);
    rst_chk("reset");
    rst_i = 1'b0;
    @(negedge clk);

    clr_tbl();
    rom[0] = 18'h0_1280;
    lat[0] = 50;
    run_seq("wr1", 0);

    clr_tbl();
    rom[0] = 18'h1_0A00;
    rdv[0] = 8'h76;
    run_seq("rd1", 0);

    clr_tbl();
    rom[0] = {2'b00, 8'($urandom), 8'($urandom)};
    rom[1] = 18'h2_0003;
    rom[2] = {2'b00, 8'($urandom), 8'($urandom)};
    run_seq("delay", 0);

    clr_tbl();
    rom[0] = 18'h0_1111;
    rom[1] = 18'h0_2222;
    lat[1] = -1;
    run_seq("tmo", 0);
    run_seq("clr_err", 0);

    clr_tbl();
    rom[0] = 18'h1_3300;
    lat[0] = TO - 1;
    run_seq("tie", 1);

    clr_tbl();
    for (int a = 0; a < N; a++) begin
      rom[a] = (a % 4 == 3) ? 18'h2_0000 : {2'b0, a[0], 8'($urandom), 8'($urandom)};
      lat[a] = $urandom_range(1, 8);
    end
    run_seq("wrap", 1);

    for (int k = 0; k < 20; k++) begin
      clr_tbl();
      for (int a = 0; a < N; a++) begin
        int r;
        r = $urandom_range(0, 11);
        if (r < 4) rom[a] = {2'b00, 8'($urandom), 8'($urandom)};
        else if (r < 8) rom[a] = {2'b01, 8'($urandom), 8'($urandom)};
        else if (r < 10) rom[a] = {2'b10, 16'($urandom_range(0, 5))};
        else rom[a] = 18'h3_0000;
        r = $urandom_range(0, 29);
        if (r == 0) lat[a] = -1;
        else if (r < 4) lat[a] = TO - 1;
      end
      run_seq($sformatf("rnd%0d", k), 1);
    end

    clr_tbl();
    rom[0] = 18'h1_4499;
    lat[0] = -1;
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid.send_pre", 3, send_o, 1);
    repeat (7) @(negedge clk);
    chk("mid.reg_pre", 10, Reg_Addr_o, 8'h44);
    chk("mid.wr_pre", 10, wr_o, 1);
    chk("mid.busy_pre", 10, busy_o, 1);
    rst_i = 1'b1;
    #1;
    rst_chk("mid");
    last_rd = '0;
    @(negedge clk);
    rst_i = 1'b0;

    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("snd.send_pre", 3, send_o, 1);
    rst_i = 1'b1;
    #1;
    chk("snd.send_drop", 3, send_o, 0);
    chk("snd.busy_drop", 3, busy_o, 0);
    @(negedge clk);
    rst_i = 1'b0;

    clr_tbl();
    rom[0] = 18'h1_5A00;
    rom[1] = 18'h0_6B7C;
    run_seq("post_rst", 0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
